// File: rtl/sram_is61wv25616_responder.sv
// -----------------------------------------------------------------------------
// sram_is61wv25616_responder
//
// Device-side model of an IS61WV25616 16-bit asynchronous SRAM, rebuilt as a
// clocked responder so it can stand in for the physical chip in simulation and
// in FPGA builds. Halfwords live in an internal array. Byte-masked writes commit
// on the rising edge. Reads are launched into an RD_LAT-deep pipeline, and the
// last stage drives SRAM_DQ combinationally whenever the current pins allow it.
//
// Parameters
//   MEM_AW  halfword address bits kept; upper SRAM_ADDR bits alias.
//   RD_LAT  cycles from read launch to DQ drive (1..3; 1 for the 5-cycle
//           32-bit controller).
//
// Ports
//   i_clk      rising-edge clock
//   i_reset    asynchronous, active-high reset (counters, pipeline valids)
//   SRAM_ADDR  halfword address
//   SRAM_DQ    bidirectional data
//   SRAM_CE_N  chip enable, active low
//   SRAM_WE_N  write enable, active low
//   SRAM_OE_N  output enable, active low
//   SRAM_LB_N  lower byte enable, active low
//   SRAM_UB_N  upper byte enable, active low
//   o_WR_CNT   committed write cycles, saturating
//   o_RD_CNT   read launches, saturating
// -----------------------------------------------------------------------------
module sram_is61wv25616_responder #(
    parameter int MEM_AW = 12,
    parameter int RD_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    input  logic        SRAM_CE_N,
    input  logic        SRAM_WE_N,
    input  logic        SRAM_OE_N,
    input  logic        SRAM_LB_N,
    input  logic        SRAM_UB_N,
    output logic [15:0] o_WR_CNT,
    output logic [15:0] o_RD_CNT
);

    localparam int DEPTH = 1 << MEM_AW;

    logic [15:0]       r_mem [DEPTH];
    logic [15:0]       r_wr_cnt;
    logic [15:0]       r_rd_cnt;

    logic [MEM_AW-1:0] w_idx;
    logic              w_write;
    logic              w_launch;
    logic              w_addr_unused;

    logic              w_out_valid;
    logic [15:0]       w_out_data;
    logic [1:0]        w_out_be;
    logic              w_drv_lo;
    logic              w_drv_hi;

    assign w_idx         = SRAM_ADDR[MEM_AW-1:0];
    // Upper address bits are deliberately ignored so the array aliases.
    assign w_addr_unused = ^SRAM_ADDR[17:MEM_AW];

    // OE_N does not participate in launch; it only gates the output drive.
    assign w_write  = !SRAM_CE_N && !SRAM_WE_N;
    assign w_launch = !SRAM_CE_N &&  SRAM_WE_N;

    // Array write port. No reset on the contents; the reset only blocks commits
    // while it is held.
    always_ff @(posedge i_clk) begin
        if (w_write && !i_reset) begin
            if (!SRAM_LB_N) r_mem[w_idx][7:0]  <= SRAM_DQ[7:0];
            if (!SRAM_UB_N) r_mem[w_idx][15:8] <= SRAM_DQ[15:8];
        end
    end

    // Read pipeline. Stage 0 is the registered array read; later stages are
    // plain shift registers. Only the valid bits need reset, which keeps the
    // array read a clean registered read.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            logic        r_valid;
            logic [15:0] r_data;
            logic [1:0]  r_be;

            if (gi == 0) begin : g_first
                always_ff @(posedge i_clk or posedge i_reset) begin
                    if (i_reset) r_valid <= 1'b0;
                    else         r_valid <= w_launch;
                end
                always_ff @(posedge i_clk) begin
                    r_data <= r_mem[w_idx];
                    r_be   <= ~{SRAM_UB_N, SRAM_LB_N};
                end
            end else begin : g_next
                always_ff @(posedge i_clk or posedge i_reset) begin
                    if (i_reset) r_valid <= 1'b0;
                    else         r_valid <= g_stage[gi-1].r_valid;
                end
                always_ff @(posedge i_clk) begin
                    r_data <= g_stage[gi-1].r_data;
                    r_be   <= g_stage[gi-1].r_be;
                end
            end
        end
    endgenerate

    assign w_out_valid = g_stage[RD_LAT-1].r_valid;
    assign w_out_data  = g_stage[RD_LAT-1].r_data;
    assign w_out_be    = g_stage[RD_LAT-1].r_be;

    // Drive depends on the live pins so a writer or deselect releases the bus
    // in the same cycle; a suppressed entry simply shifts out.
    assign w_drv_lo = w_out_valid && w_out_be[0] && !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
    assign w_drv_hi = w_out_valid && w_out_be[1] && !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;

    assign SRAM_DQ[7:0]  = w_drv_lo ? w_out_data[7:0]  : 8'hzz;
    assign SRAM_DQ[15:8] = w_drv_hi ? w_out_data[15:8] : 8'hzz;

    // Saturating access counters.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_cnt <= 16'h0000;
            r_rd_cnt <= 16'h0000;
        end else begin
            if (w_write  && (r_wr_cnt != 16'hFFFF)) r_wr_cnt <= r_wr_cnt + 16'h0001;
            if (w_launch && (r_rd_cnt != 16'hFFFF)) r_rd_cnt <= r_rd_cnt + 16'h0001;
        end
    end

    assign o_WR_CNT = r_wr_cnt;
    assign o_RD_CNT = r_rd_cnt;

endmodule

// File: tb/tb_sram_is61wv25616_responder.sv
// -----------------------------------------------------------------------------
// Bench for sram_is61wv25616_responder.
// Pins change 1 time unit after each rising edge and are sampled on the falling
// edge. On non-write cycles the bench holds every byte it expects the DUT to
// release at 8'h00, so a DUT that drives when it should not shows up as a data
// mismatch (or X) instead of an invisible 'z.
// -----------------------------------------------------------------------------
module tb_sram_is61wv25616_responder;

    localparam int MEM_AW = 12;
    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic        ce_n, we_n, oe_n, lb_n, ub_n;
    logic [15:0] drv_val;
    logic        drv_lo, drv_hi;
    wire  [15:0] dq;
    logic [15:0] wr_cnt, rd_cnt;

    always #5 clk = ~clk;

    assign dq[7:0]  = drv_lo ? drv_val[7:0]  : 8'hzz;
    assign dq[15:8] = drv_hi ? drv_val[15:8] : 8'hzz;

    sram_is61wv25616_responder #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .SRAM_ADDR (addr),
        .SRAM_DQ   (dq),
        .SRAM_CE_N (ce_n),
        .SRAM_WE_N (we_n),
        .SRAM_OE_N (oe_n),
        .SRAM_LB_N (lb_n),
        .SRAM_UB_N (ub_n),
        .o_WR_CNT  (wr_cnt),
        .o_RD_CNT  (rd_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: array contents, per-cycle scheduled read outputs, counts.
    logic [15:0] m_mem  [int];
    bit          q_valid[int];
    logic [15:0] q_data [int];
    logic [1:0]  q_be   [int];
    int          m_wr = 0;
    int          m_rd = 0;
    int          cyc  = 0;
    logic [15:0] last_dq;

    function automatic int idx_of(input logic [17:0] a);
        return int'(a) % (1 << MEM_AW);
    endfunction

    // Apply pins for one cycle and check the bus and counters mid-cycle.
    task automatic drive_check(input logic c, input logic w, input logic o,
                               input logic l, input logic u,
                               input logic [17:0] a, input logic [15:0] wd,
                               input string tag);
        bit          out_v;
        bit          e_lo, e_hi;
        logic [15:0] exp;
        @(posedge clk);
        #1;
        ce_n = c; we_n = w; oe_n = o; lb_n = l; ub_n = u; addr = a;
        out_v = q_valid.exists(cyc);
        e_lo  = out_v && q_be[cyc][0] && !c && w && !o;
        e_hi  = out_v && q_be[cyc][1] && !c && w && !o;
        if (!c && !w) begin
            drv_val = wd; drv_lo = 1'b1; drv_hi = 1'b1;
            exp = wd;
        end else begin
            drv_val = 16'h0000; drv_lo = !e_lo; drv_hi = !e_hi;
            exp[7:0]  = e_lo ? q_data[cyc][7:0]  : 8'h00;
            exp[15:8] = e_hi ? q_data[cyc][15:8] : 8'h00;
        end
        @(negedge clk);
        last_dq = dq;
        $display("cyc %0d %s ce_n=%b we_n=%b oe_n=%b lb_n=%b ub_n=%b addr=%h wd=%h dq=%h wr=%0d rd=%0d",
                 cyc, tag, c, w, o, l, u, a, wd, dq, wr_cnt, rd_cnt);
        check({tag, "_dq"}, 32'(dq), 32'(exp));
        check({tag, "_wrcnt"}, 32'(wr_cnt), 32'(m_wr));
        check({tag, "_rdcnt"}, 32'(rd_cnt), 32'(m_rd));
    endtask

    // What the upcoming rising edge does, decided from the pins and reset now.
    task automatic commit();
        int          i;
        logic [15:0] v;
        if (!rst && !ce_n) begin
            i = idx_of(addr);
            if (!we_n) begin
                v = m_mem.exists(i) ? m_mem[i] : 16'h0000;
                if (!lb_n) v[7:0]  = drv_val[7:0];
                if (!ub_n) v[15:8] = drv_val[15:8];
                m_mem[i] = v;
                if (m_wr < 65535) m_wr++;
            end else begin
                q_valid[cyc + RD_LAT] = 1'b1;
                q_data[cyc + RD_LAT]  = m_mem.exists(i) ? m_mem[i] : 16'h0000;
                q_be[cyc + RD_LAT]    = ~{ub_n, lb_n};
                if (m_rd < 65535) m_rd++;
            end
        end
        if (q_valid.exists(cyc)) begin
            q_valid.delete(cyc); q_data.delete(cyc); q_be.delete(cyc);
        end
        cyc++;
    endtask

    task automatic run_cycle(input logic c, input logic w, input logic o,
                             input logic l, input logic u,
                             input logic [17:0] a, input logic [15:0] wd,
                             input string tag);
        drive_check(c, w, o, l, u, a, wd, tag);
        commit();
    endtask

    task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic l, input logic u, input string tag);
        run_cycle(1'b0, 1'b0, 1'b1, l, u, a, d, tag);
    endtask

    task automatic rd(input logic [17:0] a, input logic o, input logic l, input logic u, input string tag);
        run_cycle(1'b0, 1'b1, o, l, u, a, 16'h0000, tag);
    endtask

    task automatic model_reset();
        q_valid.delete(); q_data.delete(); q_be.delete();
        m_wr = 0; m_rd = 0;
    endtask

    logic [15:0] lo_half;
    logic [17:0] ra;
    int          op;

    initial begin
        rst = 1'b1;
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; lb_n = 1'b1; ub_n = 1'b1;
        addr = '0; drv_val = 16'h0000; drv_lo = 1'b1; drv_hi = 1'b1;

        // Reset state.
        #12;
        check("reset_wrcnt", 32'(wr_cnt), 32'd0);
        check("reset_rdcnt", 32'(rd_cnt), 32'd0);
        run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0, "in_reset");
        rst = 1'b0;

        // Basic write then read.
        wr(18'h00010, 16'hBEEF, 1'b0, 1'b0, "wr_beef");
        rd(18'h00010, 1'b0, 1'b0, 1'b0, "rd_launch");
        rd(18'h00010, 1'b0, 1'b0, 1'b0, "rd_out");
        check("beef_value", 32'(last_dq), 32'h0000BEEF);
        run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0, "idle");

        // Byte masks.
        wr(18'h00020, 16'h1234, 1'b0, 1'b0, "wr_1234");
        wr(18'h00020, 16'hAB00, 1'b1, 1'b0, "wr_ub_ab");
        rd(18'h00020, 1'b0, 1'b0, 1'b0, "rd_both");
        rd(18'h00020, 1'b0, 1'b0, 1'b1, "rd_lo_only");
        check("mask_both", 32'(last_dq), 32'h0000AB34);
        rd(18'h00020, 1'b0, 1'b0, 1'b0, "rd_after_lo");
        wr(18'h00020, 16'hFFFF, 1'b1, 1'b1, "wr_no_bytes");
        rd(18'h00020, 1'b0, 1'b0, 1'b0, "rd_unchanged");
        rd(18'h00020, 1'b0, 1'b0, 1'b0, "rd_unchanged_out");

        // Aliasing.
        wr(18'h01005, 16'h5A5A, 1'b0, 1'b0, "wr_alias");
        rd(18'h00005, 1'b0, 1'b0, 1'b0, "rd_alias");
        rd(18'h00005, 1'b0, 1'b0, 1'b0, "rd_alias_out");
        check("alias_value", 32'(last_dq), 32'h00005A5A);

        // Turnaround: write right after a read launch, then OE_N high on output.
        wr(18'h00030, 16'h7788, 1'b0, 1'b0, "wr_30");
        rd(18'h00030, 1'b0, 1'b0, 1'b0, "rd_30");
        wr(18'h00031, 16'h99AA, 1'b0, 1'b0, "wr_after_rd");
        rd(18'h00030, 1'b0, 1'b0, 1'b0, "rd_30_again");
        rd(18'h00031, 1'b1, 1'b0, 1'b0, "oe_high_out");
        rd(18'h00031, 1'b0, 1'b0, 1'b0, "rd_31_out");
        check("turn_wr_commit", 32'(last_dq), 32'h000099AA);

        // 32-bit pairing: low halfword at even, high at odd address.
        wr(18'h00040, 16'hF00D, 1'b0, 1'b0, "wr_lo40");
        wr(18'h00041, 16'hCAFE, 1'b0, 1'b0, "wr_hi41");
        rd(18'h00040, 1'b0, 1'b0, 1'b0, "rd_40");
        rd(18'h00041, 1'b0, 1'b0, 1'b0, "rd_41");
        lo_half = last_dq;
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00041, 16'h0, "rd_41_out");
        check("pair_word", {last_dq, lo_half}, 32'hCAFEF00D);

        // Asynchronous reset while the output stage is valid.
        wr(18'h00050, 16'h1357, 1'b0, 1'b0, "wr_50");
        rd(18'h00050, 1'b0, 1'b0, 1'b0, "rd_50");
        drive_check(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00050, 16'h0, "rd_50_out");
        #2;
        rst = 1'b1;
        drv_val = 16'h0000; drv_lo = 1'b1; drv_hi = 1'b1;
        #1;
        check("async_rst_dq", 32'(dq), 32'h0);
        check("async_rst_wrcnt", 32'(wr_cnt), 32'd0);
        check("async_rst_rdcnt", 32'(rd_cnt), 32'd0);
        model_reset();
        commit();
        wr(18'h00050, 16'hFFFF, 1'b0, 1'b0, "wr_in_rst");
        rd(18'h00050, 1'b0, 1'b0, 1'b0, "rd_in_rst");
        ce_n = 1'b1;
        rst  = 1'b0;
        rd(18'h00050, 1'b0, 1'b0, 1'b0, "rd_50_post");
        rd(18'h00050, 1'b0, 1'b0, 1'b0, "rd_50_post_out");
        check("post_rst_value", 32'(last_dq), 32'h00001357);

        // Randomized traffic over a pre-written address window.
        for (int i = 0; i < 16; i++)
            wr(18'(18'h00100 + i), 16'($urandom), 1'b0, 1'b0, "prefill");
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 3));
            ra = 18'(18'h00100 + $urandom_range(0, 15) + ($urandom_range(0, 63) << 12));
            case (op)
                0: run_cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                             ra, 16'h0, "rnd_idle");
                1: wr(ra, 16'($urandom), 1'($urandom), 1'($urandom), "rnd_wr");
                default: rd(ra, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), "rnd_rd");
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
